vga_fb_scanout: RTL and testbench
=================================

# vga_fb_scanout

Parametrised framebuffer scan-out engine replacing the fixed 1-bit-per-pixel VGA path in the top level. It generates VGA sync timing and reads packed pixels from the byte-wide VRAM's second port. Pixels with fewer than 8 bits index a CPU-writable palette; 8-bit pixels drive RGB332 directly. The framebuffer base address is latched once per frame, so the CPU can page-flip and scroll tear-free.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- BPP, 1, bits per pixel, one of 1, 2, 4 or 8; PPB = 8/BPP pixels per byte
- VRAM_AW, 16, VRAM byte-address width
---
- clk  in  1  pixel clock (clk25); single clock domain
- clr  in  1  synchronous, active-high reset
- fb_base  in  VRAM_AW  framebuffer start byte address; sampled at frame boundary
- pal_we  in  1  palette write strobe
- pal_idx  in  max(BPP,1)  palette entry index; ignored when BPP=8
- pal_data  in  8  RGB332 palette value
- vram_addr  out  VRAM_AW  VRAM read address, registered
- vram_dout  in  8  VRAM read data; valid one clock after vram_addr
- hsync, vsync  out  1  active-low syncs, registered
- vidon  out  1  high while a visible pixel is on red/green/blue
- vblank  out  1  high while vcnt >= V_ACTIVE, aligned with the pins
- red  out  3, green out 3, blue out 2  pixel colour; 0 when vidon=0

## Operation
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800 by default).
  - vcnt increments when hcnt wraps, and runs 0..V_TOTAL-1 (525 by default).
  - A counter position is active when hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Sync:
  - hsync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync is low for vcnt in [490, 491].
- Frame boundary (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1):
  - frame_base ← fb_base.
  - line_ptr ← fb_base.
  - byte_ptr ← fb_base.
- Fetch:
  - At each active position with hcnt mod PPB = 0, drive vram_addr ← byte_ptr, then byte_ptr ← byte_ptr+1.
  - Otherwise vram_addr holds its value.
- Line end (hcnt=H_TOTAL-1, active line):
  - line_ptr ← line_ptr + H_ACTIVE/PPB.
  - byte_ptr ← the new line_ptr.
- Address arithmetic is modulo 2^VRAM_AW. Wrap from all-ones to 0 is legal and silent.
- Unpacking:
  - Fetched byte is loaded into a shift register.
  - Pixel k (k=0 leftmost) of a byte is bits [k*BPP +: BPP], LSB-first.
- Colour:
  - BPP<8: colour = pal[pixel].
  - BPP=8: colour = pixel.
  - red=colour[7:5], green=colour[4:2], blue=colour[1:0].
- Palette:
  - 2^BPP × 8 registers; unused when BPP=8.
  - A write takes effect on the next clock. Same-cycle lookup of the written entry returns the old value.

## Timing
- Pipeline latency LAT=3: outputs at cycle t+3 reflect counter position (hcnt,vcnt) at cycle t.
  - t+1: vram_addr.
  - t+2: vram_dout sampled.
  - t+3: palette and output registers.
- hsync, vsync, vidon and vblank pass through the same 3-stage delay, so sync and colour stay exactly aligned.
- One VRAM read per PPB pixels. No stalls; VRAM read port is always available.
- clr (synchronous, any time including mid-line):
  - Next edge: hcnt=vcnt=0, all delay stages cleared.
  - Outputs: hsync=vsync=1, vidon=0, vblank=0, red/green/blue=0, vram_addr=0.
  - frame_base, line_ptr, byte_ptr ← fb_base.
  - Palette: pal[0]=8'h00, all other entries 8'hFF.
- After clr deasserts, the first visible pixel appears 3 clocks after counters leave reset (counter position (0,0)).
- fb_base changes mid-frame have no effect until the next frame boundary.

## Test plan
- Sync timing (default params): after clr, hsync falls 659 clocks after the first (0,0) cycle and stays low 96 clocks. Line period 800, vsync low for 2 lines, frame period 420000 clocks.
- BPP=1, fb_base=0, VRAM[0]=8'hA5: pixels 0..7 give red=7,0,7,0,0,7,0,7 (blue 3/0 likewise). vram_addr steps 0,1,2… every 8 pixels, and line 1 starts at 80.
- BPP=8, VRAM[0]=8'hE3: pixel 0 gives red=7, green=0, blue=3. Pixel under blanking gives 0 with vidon=0.
- BPP=2, write pal[2]=8'h1C, VRAM byte 8'h02: pixel 0 gives green=7 and pixels 1..3 give pal[0]=0. A write then immediate use of the same entry shows the old value for exactly one pixel.
- Page flip and wrap: set fb_base=16'hFFF0 mid-frame. Current frame is unchanged. Next frame's fetches read FFF0..FFFF then 0000.
- Reset mid-line: assert clr at hcnt=300 for 1 clock. Next edge shows reset values on all outputs, and sync timing restarts from (0,0).

Source files
------------

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA timing generator plus packed-pixel framebuffer scan-out.
// Counters walk the raster, a fetch stage reads one VRAM byte per PPB pixels,
// a shift register unpacks pixels LSB-first, and an optional palette maps
// them to RGB332. Sync, blanking and colour share one 3-stage delay so they
// leave the block exactly aligned.
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BPP      = 1,
    parameter int VRAM_AW  = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [VRAM_AW-1:0] fb_base,
    input  logic               pal_we,
    input  logic [BPP-1:0]     pal_idx,
    input  logic [7:0]         pal_data,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_dout,
    output logic               hsync,
    output logic               vsync,
    output logic               vidon,
    output logic               vblank,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int PPB        = 8 / BPP;
    localparam int PAL_N      = 2 ** BPP;
    localparam int LINE_BYTES = H_ACTIVE / PPB;
    localparam int HS_START   = H_ACTIVE + H_FP;
    localparam int HS_END     = HS_START + H_SYNC - 1;
    localparam int VS_START   = V_ACTIVE + V_FP;
    localparam int VS_END     = VS_START + V_SYNC - 1;

    // PPB is a power of two, so "hcnt mod PPB == 0" is a test of the low bits.
    localparam logic [HW-1:0] PPB_MASK = HW'(PPB - 1);

    // Per-position control bits carried down the delay line beside the data.
    typedef struct packed {
        logic vidon;
        logic hsync;
        logic vsync;
        logic vblank;
        logic load;     // this position starts a new VRAM byte
    } stage_t;

    localparam stage_t STAGE_IDLE = '{vidon: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                      vblank: 1'b0, load: 1'b0};

    // Raster counters and fetch pointers.
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [VRAM_AW-1:0] line_ptr_q, line_ptr_d;
    logic [VRAM_AW-1:0] byte_ptr_q, byte_ptr_d;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;

    // Delay line: stage 1 lines up with vram_addr, stage 2 with vram_dout.
    stage_t s1_q, s2_q;

    // Unpacking and output registers.
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     byte_src;
    logic [BPP-1:0] pix;
    logic [7:0]     colour;
    logic [7:0]     colour_q;
    logic           hsync_q, vsync_q, vidon_q, vblank_q;

    // Decoded view of the current counter position.
    logic h_last, v_last, h_active, v_active;
    logic active0, hs0, vs0, vb0, fetch0;

    // Decode the current raster position into sync, blanking and fetch flags.
    // NOTE: every signal written in an always_comb is given a value before any
    // condition, so the block never has a path that holds state (no latch).
    always_comb begin
        h_last   = (hcnt_q == HW'(H_TOTAL - 1));
        v_last   = (vcnt_q == VW'(V_TOTAL - 1));
        h_active = (hcnt_q < HW'(H_ACTIVE));
        v_active = (vcnt_q < VW'(V_ACTIVE));
        active0  = h_active && v_active;
        hs0      = !((hcnt_q >= HW'(HS_START)) && (hcnt_q <= HW'(HS_END)));
        vs0      = !((vcnt_q >= VW'(VS_START)) && (vcnt_q <= VW'(VS_END)));
        vb0      = !v_active;
        fetch0   = active0 && ((hcnt_q & PPB_MASK) == '0);
    end

    // Next-state for counters, line/byte pointers and the VRAM address.
    always_comb begin
        hcnt_d      = hcnt_q + HW'(1);
        vcnt_d      = vcnt_q;
        line_ptr_d  = line_ptr_q;
        byte_ptr_d  = byte_ptr_q;
        vram_addr_d = vram_addr_q;

        if (fetch0) begin
            vram_addr_d = byte_ptr_q;
            byte_ptr_d  = byte_ptr_q + VRAM_AW'(1);
        end

        if (h_last) begin
            hcnt_d = '0;
            if (v_last) begin
                // Frame boundary: the only point where a new base is taken,
                // which is what makes page flips and scrolls tear-free.
                vcnt_d     = '0;
                line_ptr_d = fb_base;
                byte_ptr_d = fb_base;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
                if (v_active) begin
                    line_ptr_d = line_ptr_q + VRAM_AW'(LINE_BYTES);
                    byte_ptr_d = line_ptr_q + VRAM_AW'(LINE_BYTES);
                end
            end
        end
    end

    // Raster counters, pointers and the registered VRAM address.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register in the design samples pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (clr) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            line_ptr_q  <= fb_base;
            byte_ptr_q  <= fb_base;
            vram_addr_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            line_ptr_q  <= line_ptr_d;
            byte_ptr_q  <= byte_ptr_d;
            vram_addr_q <= vram_addr_d;
        end
    end

    // Pick this position's pixel: a fresh byte from VRAM or the shifted remainder.
    always_comb begin
        byte_src = s2_q.load ? vram_dout : shreg_q;
        pix      = byte_src[BPP-1:0];
        shreg_d  = byte_src >> BPP;
    end

    generate
        if (BPP < 8) begin : g_pal
            logic [7:0] pal_q [PAL_N];

            // CPU-writable palette; a write is visible from the next clock on.
            // NOTE: the palette is a small flop-based register file with a fixed
            // reset image (entry 0 black, the rest white), so it is reset in
            // place rather than left undefined like a RAM would be.
            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < PAL_N; i++) begin
                        pal_q[i] <= (i == 0) ? 8'h00 : 8'hFF;
                    end
                end else if (pal_we) begin
                    pal_q[pal_idx] <= pal_data;
                end
            end

            assign colour = pal_q[pix];
        end else begin : g_direct
            // 8-bit pixels are already RGB332; the palette port is not used.
            logic unused_pal;
            assign unused_pal = &{1'b0, pal_we, pal_idx, pal_data};
            assign colour     = pix;
        end
    endgenerate

    // Delay line for control, the unpacking shift register and output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q     <= STAGE_IDLE;
            s2_q     <= STAGE_IDLE;
            shreg_q  <= '0;
            colour_q <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            vidon_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            s1_q     <= '{vidon: active0, hsync: hs0, vsync: vs0,
                          vblank: vb0, load: fetch0};
            s2_q     <= s1_q;
            shreg_q  <= shreg_d;
            colour_q <= s2_q.vidon ? colour : 8'h00;
            hsync_q  <= s2_q.hsync;
            vsync_q  <= s2_q.vsync;
            vidon_q  <= s2_q.vidon;
            vblank_q <= s2_q.vblank;
        end
    end

    assign vram_addr = vram_addr_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign vidon     = vidon_q;
    assign vblank    = vblank_q;
    assign red       = colour_q[7:5];
    assign green     = colour_q[4:2];
    assign blue      = colour_q[1:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Testbench for vga_fb_scanout: three instances (BPP 1, 8 and 2) on a shrunken
// 24x8 raster share clock and clr; each has its own VRAM read port on a shared
// memory image. Expected pixels and addresses are hand-computed tables.
module tb_vga_fb_scanout;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;   // H_TOTAL 24, hsync low 18..20
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;   // V_TOTAL 8,  vsync low 5..6

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] fb_base1, fb_base8, fb_base2;
    logic        pal_we2;
    logic [1:0]  pal_idx2;
    logic [7:0]  pal_data2;

    logic [15:0] addr1, addr8, addr2;
    logic [7:0]  dout1, dout8, dout2;
    logic        hs1, vs1, von1, vb1;
    logic        hs8, vs8, von8, vb8;
    logic        hs2, vs2, von2, vb2;
    logic [2:0]  r1, g1, r8, g8, r2, g2;
    logic [1:0]  b1, b8, b2;

    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;

    // Synchronous VRAM read ports: data valid one clock after the address.
    always @(posedge clk) begin
        dout1 <= mem[addr1];
        dout8 <= mem[addr8];
        dout2 <= mem[addr2];
    end

    vga_fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .BPP(1), .VRAM_AW(16)) u1 (
        .clk(clk), .clr(clr), .fb_base(fb_base1),
        .pal_we(1'b0), .pal_idx(1'b0), .pal_data(8'h00),
        .vram_addr(addr1), .vram_dout(dout1),
        .hsync(hs1), .vsync(vs1), .vidon(von1), .vblank(vb1),
        .red(r1), .green(g1), .blue(b1));

    vga_fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .BPP(8), .VRAM_AW(16)) u8 (
        .clk(clk), .clr(clr), .fb_base(fb_base8),
        .pal_we(1'b0), .pal_idx(8'h00), .pal_data(8'h00),
        .vram_addr(addr8), .vram_dout(dout8),
        .hsync(hs8), .vsync(vs8), .vidon(von8), .vblank(vb8),
        .red(r8), .green(g8), .blue(b8));

    vga_fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .BPP(2), .VRAM_AW(16)) u2 (
        .clk(clk), .clr(clr), .fb_base(fb_base2),
        .pal_we(pal_we2), .pal_idx(pal_idx2), .pal_data(pal_data2),
        .vram_addr(addr2), .vram_dout(dout2),
        .hsync(hs2), .vsync(vs2), .vidon(von2), .vblank(vb2),
        .red(r2), .green(g2), .blue(b2));

    typedef struct {
        int         cyc;
        int         dut;     // 0: BPP1, 1: BPP8, 2: BPP2
        logic [7:0] rgb;
        logic       vidon;
        logic       hs;
        logic       vs;
        logic       vb;
    } pix_vec_t;

    typedef struct {
        int          cyc;
        int          dut;
        logic [15:0] addr;
    } addr_vec_t;

    pix_vec_t  pv[$];
    addr_vec_t av[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add_p(input int c, input int d, input logic [7:0] rgb,
                         input logic von, input logic hs, input logic vs, input logic vb);
        pv.push_back('{c, d, rgb, von, hs, vs, vb});
    endtask

    task automatic add_a(input int c, input int d, input logic [15:0] a);
        av.push_back('{c, d, a});
    endtask

    function automatic logic [11:0] get_pix(input int d);
        case (d)
            0:       return {r1, g1, b1, von1, hs1, vs1, vb1};
            1:       return {r8, g8, b8, von8, hs8, vs8, vb8};
            default: return {r2, g2, b2, von2, hs2, vs2, vb2};
        endcase
    endfunction

    function automatic logic [15:0] get_addr(input int d);
        case (d)
            0:       return addr1;
            1:       return addr8;
            default: return addr2;
        endcase
    endfunction

    function automatic string dname(input int d);
        case (d)
            0:       return "bpp1";
            1:       return "bpp8";
            default: return "bpp2";
        endcase
    endfunction

    initial begin
        int pi;
        int ai;
        pi = 0;
        ai = 0;

        clr       = 1'b1;
        fb_base1  = 16'h0000;
        fb_base8  = 16'h0100;
        fb_base2  = 16'h0200;
        pal_we2   = 1'b0;
        pal_idx2  = 2'd0;
        pal_data2 = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'hA5;  mem[16'h0001] = 8'h3C;  mem[16'h0002] = 8'h0F;
        mem[16'h0100] = 8'hE3;  mem[16'h0101] = 8'h1C;  mem[16'h0110] = 8'h5A;
        mem[16'h0200] = 8'h02;  mem[16'h0201] = 8'hE4;  mem[16'hFFFC] = 8'h01;

        // Cycle c = 0 is the first (0,0) counter cycle; outputs show position c-3.
        // Reset state and pipeline fill.
        add_p(0, 0, 8'h00, 0, 1, 1, 0); add_p(0, 1, 8'h00, 0, 1, 1, 0); add_p(0, 2, 8'h00, 0, 1, 1, 0);
        add_p(2, 0, 8'h00, 0, 1, 1, 0);
        // Frame 0: BPP1 byte A5 LSB-first, BPP8 direct, BPP2 with reset palette.
        add_p(3, 0, 8'hFF, 1, 1, 1, 0); add_p(3, 1, 8'hE3, 1, 1, 1, 0); add_p(3, 2, 8'hFF, 1, 1, 1, 0);
        add_p(4, 0, 8'h00, 1, 1, 1, 0); add_p(4, 1, 8'h1C, 1, 1, 1, 0); add_p(4, 2, 8'h00, 1, 1, 1, 0);
        add_p(5, 0, 8'hFF, 1, 1, 1, 0); add_p(5, 1, 8'h00, 1, 1, 1, 0);
        add_p(6, 0, 8'h00, 1, 1, 1, 0);
        add_p(7, 0, 8'h00, 1, 1, 1, 0); add_p(7, 2, 8'h00, 1, 1, 1, 0);
        add_p(8, 0, 8'hFF, 1, 1, 1, 0); add_p(8, 2, 8'hFF, 1, 1, 1, 0);
        add_p(9, 0, 8'h00, 1, 1, 1, 0); add_p(9, 2, 8'hFF, 1, 1, 1, 0);
        add_p(10, 0, 8'hFF, 1, 1, 1, 0); add_p(10, 2, 8'hFF, 1, 1, 1, 0);
        add_p(11, 0, 8'h00, 1, 1, 1, 0);
        add_p(13, 0, 8'hFF, 1, 1, 1, 0);
        // Horizontal blanking and sync edges.
        add_p(19, 0, 8'h00, 0, 1, 1, 0); add_p(19, 1, 8'h00, 0, 1, 1, 0);
        add_p(20, 0, 8'h00, 0, 1, 1, 0);
        add_p(21, 0, 8'h00, 0, 0, 1, 0);
        add_p(23, 0, 8'h00, 0, 0, 1, 0);
        add_p(24, 0, 8'h00, 0, 1, 1, 0);
        // Line 1.
        add_p(27, 0, 8'hFF, 1, 1, 1, 0); add_p(27, 1, 8'h5A, 1, 1, 1, 0);
        add_p(31, 0, 8'h00, 1, 1, 1, 0);
        // Vertical blanking and vsync.
        add_p(99, 0, 8'h00, 0, 1, 1, 1);
        add_p(123, 0, 8'h00, 0, 1, 0, 1);
        add_p(142, 0, 8'h00, 0, 0, 0, 1);
        add_p(170, 0, 8'h00, 0, 1, 0, 1);
        add_p(171, 0, 8'h00, 0, 1, 1, 1);
        // Frame 1: palette entry 2 rewritten to 1C during frame 0.
        add_p(195, 0, 8'hFF, 1, 1, 1, 0); add_p(195, 2, 8'h1C, 1, 1, 1, 0);
        add_p(196, 2, 8'h00, 1, 1, 1, 0);
        add_p(198, 2, 8'h00, 1, 1, 1, 0);
        add_p(199, 2, 8'h00, 1, 1, 1, 0);
        add_p(201, 2, 8'h1C, 1, 1, 1, 0);
        // pal[0] <= E0 on the same edge that looks up pixel (1,1): old value once.
        add_p(219, 2, 8'h00, 1, 1, 1, 0);
        add_p(220, 2, 8'h00, 1, 1, 1, 0);
        add_p(221, 2, 8'hE0, 1, 1, 1, 0);
        add_p(222, 2, 8'hE0, 1, 1, 1, 0);
        // Frame 2: page flipped to FFFC, line 2 wraps to 0000 (byte A5).
        add_p(387, 0, 8'hFF, 1, 1, 1, 0);
        add_p(388, 0, 8'h00, 1, 1, 1, 0);
        add_p(442, 0, 8'hFF, 1, 1, 1, 0);
        // Mid-line clr: reset values next edge, then a clean restart.
        add_p(443, 0, 8'h00, 0, 1, 1, 0); add_p(443, 1, 8'h00, 0, 1, 1, 0); add_p(443, 2, 8'h00, 0, 1, 1, 0);
        add_p(445, 0, 8'h00, 0, 1, 1, 0);
        add_p(446, 0, 8'hFF, 1, 1, 1, 0); add_p(446, 1, 8'hE3, 1, 1, 1, 0); add_p(446, 2, 8'hFF, 1, 1, 1, 0);
        add_p(447, 0, 8'h00, 1, 1, 1, 0); add_p(447, 2, 8'h00, 1, 1, 1, 0);
        add_p(463, 0, 8'h00, 0, 1, 1, 0);
        add_p(464, 0, 8'h00, 0, 0, 1, 0);
        add_p(466, 0, 8'h00, 0, 0, 1, 0);
        add_p(467, 0, 8'h00, 0, 1, 1, 0);

        // VRAM addresses: value at cycle c comes from the fetch at position c-1.
        add_a(0, 0, 16'h0000); add_a(0, 1, 16'h0000); add_a(0, 2, 16'h0000);
        add_a(1, 1, 16'h0100); add_a(1, 2, 16'h0200);
        add_a(2, 1, 16'h0101);
        add_a(4, 2, 16'h0200);
        add_a(5, 2, 16'h0201);
        add_a(9, 0, 16'h0001);
        add_a(25, 0, 16'h0002);
        add_a(193, 0, 16'h0000);
        add_a(201, 0, 16'h0001);
        add_a(217, 0, 16'h0002);
        add_a(273, 0, 16'h0007);
        add_a(385, 0, 16'hFFFC);
        add_a(390, 0, 16'hFFFC);
        add_a(393, 0, 16'hFFFD);
        add_a(409, 0, 16'hFFFE);
        add_a(417, 0, 16'hFFFF);
        add_a(433, 0, 16'h0000);
        add_a(441, 0, 16'h0001);
        add_a(443, 0, 16'h0000); add_a(443, 1, 16'h0000); add_a(443, 2, 16'h0000);
        add_a(444, 0, 16'hFFFC); add_a(444, 1, 16'h0100);

        repeat (2) @(negedge clk);

        for (int c = 0; c <= 470; c++) begin
            @(negedge clk);
            while (pi < pv.size() && pv[pi].cyc == c) begin
                check($sformatf("pix c=%0d %s {rgb,vidon,hs,vs,vb}", c, dname(pv[pi].dut)),
                      32'(get_pix(pv[pi].dut)),
                      32'({pv[pi].rgb, pv[pi].vidon, pv[pi].hs, pv[pi].vs, pv[pi].vb}));
                pi++;
            end
            while (ai < av.size() && av[ai].cyc == c) begin
                check($sformatf("vram_addr c=%0d %s", c, dname(av[ai].dut)),
                      32'(get_addr(av[ai].dut)), 32'(av[ai].addr));
                ai++;
            end
            // Stimulus for the coming edge.
            case (c)
                0:   clr = 1'b0;
                100: begin pal_we2 = 1'b1; pal_idx2 = 2'd2; pal_data2 = 8'h1C; end
                101: pal_we2 = 1'b0;
                219: begin pal_we2 = 1'b1; pal_idx2 = 2'd0; pal_data2 = 8'hE0; end
                220: pal_we2 = 1'b0;
                250: fb_base1 = 16'hFFFC;
                442: clr = 1'b1;
                443: clr = 1'b0;
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
